// File: rtl/axi_lite_spi_slave.sv
// AXI4-Lite controlled SPI target, mode 0, MSB first, 8-bit frames.
// SPI pins are synchronized into ACLK; all logic runs on ACLK.
module axi_lite_spi_slave #(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
   input  logic [2:0]                S_AXI_awprot,
   input  logic                      S_AXI_awvalid,
   output logic                      S_AXI_awready,
   input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
   input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
   input  logic                      S_AXI_wvalid,
   output logic                      S_AXI_wready,
   output logic [1:0]                S_AXI_bresp,
   output logic                      S_AXI_bvalid,
   input  logic                      S_AXI_bready,
   input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
   input  logic [2:0]                S_AXI_arprot,
   input  logic                      S_AXI_arvalid,
   output logic                      S_AXI_arready,
   output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
   output logic [1:0]                S_AXI_rresp,
   output logic                      S_AXI_rvalid,
   output logic                      S_AXI_rlast,
   input  logic                      S_AXI_rready,
   input  logic                      spi_cs_n,
   input  logic                      spi_sclk,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   output logic                      spi_miso_oe,
   output logic                      irq
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);

   localparam logic [1:0] IDX_TXDATA = 2'd0;
   localparam logic [1:0] IDX_RXDATA = 2'd1;
   localparam logic [1:0] IDX_STATUS = 2'd2;
   localparam logic [1:0] IDX_CTRL   = 2'd3;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } spi_state_t;

   spi_state_t state, state_next;

   // Synchronizer chains; index 0 is the pin-side flop.
   logic [2:0] cs_sync;
   logic [2:0] sclk_sync;
   logic [1:0] mosi_sync;
   logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

   // SPI datapath
   logic [2:0] bit_cnt;
   logic [7:0] shift_rx;
   logic [7:0] shift_tx;
   logic       reload_pending;
   logic [7:0] rx_byte;

   // FSM event strobes
   logic       load_tx, shift_en, sample, commit, clear_frame;

   // Register file
   logic [7:0] tx_buf;
   logic       tx_valid;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic       ctrl_enable;
   logic       ctrl_irq_en;
   logic       busy;

   // AXI handshake helpers
   logic                  aw_accept, wr_fire, ar_accept, rd_fire;
   logic [1:0]            wr_idx, rd_idx;
   logic                  wr_tx, wr_status, wr_ctrl, rd_rx, rx_avail;
   logic [DATA_WIDTH-1:0] rd_word;

   // Protection bits, byte strobes and upper address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_wstrb,
                          S_AXI_awaddr, S_AXI_araddr, S_AXI_wdata};

   // Bring SPI pins into the ACLK domain; cs/sclk get an extra flop for edge detection.
   // cs_n resets low so that a CS already asserted at reset release is not seen as a new frame.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cs_sync   <= 3'b000;
         sclk_sync <= 3'b000;
         mosi_sync <= 2'b00;
      end else begin
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         sclk_sync <= {sclk_sync[1:0], spi_sclk};
         mosi_sync <= {mosi_sync[0], spi_mosi};
      end
   end

   assign cs_fall   =  cs_sync[2]   & ~cs_sync[1];
   assign cs_rise   = ~cs_sync[2]   &  cs_sync[1];
   assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
   assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
   assign rx_byte   = {shift_rx[6:0], mosi_sync[1]};

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= ST_IDLE;
      else          state <= state_next;
   end

   // FSM next state and per-cycle SPI event strobes.
   always_comb begin
      state_next  = state;
      load_tx     = 1'b0;
      shift_en    = 1'b0;
      sample      = 1'b0;
      commit      = 1'b0;
      clear_frame = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl_enable && cs_fall) begin
               state_next  = ST_ACTIVE;
               load_tx     = 1'b1;
               clear_frame = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!ctrl_enable || cs_rise) begin
               // Partial bytes are dropped on abort.
               state_next  = ST_IDLE;
               clear_frame = 1'b1;
            end else begin
               if (sclk_rise) begin
                  sample = 1'b1;
                  commit = (bit_cnt == 3'd7);
               end
               if (sclk_fall) begin
                  if (bit_cnt != 3'd0)  shift_en = 1'b1;
                  else if (reload_pending) load_tx = 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy        = (state == ST_ACTIVE);
   assign spi_miso_oe = busy & ctrl_enable;
   assign spi_miso    = spi_miso_oe & shift_tx[7];

   // Shift registers and bit counter; bit_cnt wraps 7->0 on the commit edge.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bit_cnt        <= 3'd0;
         shift_rx       <= 8'd0;
         shift_tx       <= 8'd0;
         reload_pending <= 1'b0;
      end else begin
         if (clear_frame) begin
            bit_cnt        <= 3'd0;
            reload_pending <= 1'b0;
         end else begin
            if (sample) begin
               shift_rx <= rx_byte;
               bit_cnt  <= bit_cnt + 3'd1;
               if (commit) reload_pending <= 1'b1;
            end
            if (shift_en) shift_tx <= {shift_tx[6:0], 1'b0};
         end
         if (load_tx) begin
            shift_tx       <= tx_valid ? tx_buf : FILL_BYTE;
            reload_pending <= 1'b0;
         end
      end
   end

   // AXI address decode and transfer qualifiers.
   assign aw_accept = S_AXI_awvalid & S_AXI_wvalid & ~S_AXI_bvalid & ~S_AXI_awready;
   assign wr_fire   = S_AXI_awready & S_AXI_awvalid & S_AXI_wready & S_AXI_wvalid;
   assign ar_accept = S_AXI_arvalid & ~S_AXI_rvalid & ~S_AXI_arready;
   assign rd_fire   = S_AXI_arready & S_AXI_arvalid;
   assign wr_idx    = S_AXI_awaddr[ADDR_LSB +: 2];
   assign rd_idx    = S_AXI_araddr[ADDR_LSB +: 2];
   assign wr_tx     = wr_fire & (wr_idx == IDX_TXDATA);
   assign wr_status = wr_fire & (wr_idx == IDX_STATUS);
   assign wr_ctrl   = wr_fire & (wr_idx == IDX_CTRL);
   assign rd_rx     = rd_fire & (rd_idx == IDX_RXDATA);
   // A byte landing while RXDATA is being read takes the slot the read frees.
   assign rx_avail  = rx_valid & ~rd_rx;

   // Register file; later assignments give set-wins / write-wins priority.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tx_buf      <= 8'd0;
         tx_valid    <= 1'b0;
         rx_data     <= 8'd0;
         rx_valid    <= 1'b0;
         overrun     <= 1'b0;
         ctrl_enable <= 1'b1;
         ctrl_irq_en <= 1'b0;
      end else begin
         if (load_tx) tx_valid <= 1'b0;
         if (wr_tx) begin
            tx_buf   <= S_AXI_wdata[7:0];
            tx_valid <= 1'b1;
         end
         if (rd_rx) rx_valid <= 1'b0;
         if (commit && !rx_avail) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
         end
         if (wr_status && S_AXI_wdata[3]) overrun <= 1'b0;
         if (commit && rx_avail) overrun <= 1'b1;
         if (wr_ctrl) begin
            ctrl_enable <= S_AXI_wdata[0];
            ctrl_irq_en <= S_AXI_wdata[1];
         end
      end
   end

   // Read data multiplexer.
   always_comb begin
      rd_word = '0;
      case (rd_idx)
         IDX_TXDATA: rd_word[7:0] = tx_buf;
         IDX_RXDATA: rd_word[7:0] = rx_data;
         IDX_STATUS: rd_word[3:0] = {overrun, busy, tx_valid, rx_valid};
         IDX_CTRL:   rd_word[1:0] = {ctrl_irq_en, ctrl_enable};
         default:    rd_word = '0;
      endcase
   end

   // AXI handshake and response channel registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_awready <= 1'b0;
         S_AXI_wready  <= 1'b0;
         S_AXI_bvalid  <= 1'b0;
         S_AXI_arready <= 1'b0;
         S_AXI_rvalid  <= 1'b0;
         S_AXI_rdata   <= '0;
      end else begin
         S_AXI_awready <= aw_accept;
         S_AXI_wready  <= aw_accept;
         if (wr_fire)           S_AXI_bvalid <= 1'b1;
         else if (S_AXI_bready) S_AXI_bvalid <= 1'b0;
         S_AXI_arready <= ar_accept;
         if (rd_fire) begin
            S_AXI_rvalid <= 1'b1;
            S_AXI_rdata  <= rd_word;
         end else if (S_AXI_rready) begin
            S_AXI_rvalid <= 1'b0;
         end
      end
   end

   assign S_AXI_bresp = 2'b00;
   assign S_AXI_rresp = 2'b00;
   assign S_AXI_rlast = S_AXI_rvalid;
   assign irq         = ctrl_irq_en & rx_valid;

endmodule

// File: tb/tb_axi_lite_spi_slave.sv
// Directed bench for axi_lite_spi_slave: bit-banged SPI master plus AXI-Lite register accesses.
module tb_axi_lite_spi_slave;

   localparam int HALF = 8;   // SCLK half period in ACLK cycles

   localparam logic [31:0] A_TX   = 32'h0;
   localparam logic [31:0] A_RX   = 32'h4;
   localparam logic [31:0] A_STAT = 32'h8;
   localparam logic [31:0] A_CTRL = 32'hC;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] S_AXI_awaddr;
   logic [2:0]  S_AXI_awprot;
   logic        S_AXI_awvalid;
   logic        S_AXI_awready;
   logic [31:0] S_AXI_wdata;
   logic [3:0]  S_AXI_wstrb;
   logic        S_AXI_wvalid;
   logic        S_AXI_wready;
   logic [1:0]  S_AXI_bresp;
   logic        S_AXI_bvalid;
   logic        S_AXI_bready;
   logic [31:0] S_AXI_araddr;
   logic [2:0]  S_AXI_arprot;
   logic        S_AXI_arvalid;
   logic        S_AXI_arready;
   logic [31:0] S_AXI_rdata;
   logic [1:0]  S_AXI_rresp;
   logic        S_AXI_rvalid;
   logic        S_AXI_rlast;
   logic        S_AXI_rready;
   logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe, irq;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   axi_lite_spi_slave dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
      .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
      .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
      .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
      .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
      .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
      .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
      .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
      .S_AXI_rlast(S_AXI_rlast), .S_AXI_rready(S_AXI_rready),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
      int n;
      @(negedge ACLK);
      S_AXI_awaddr = addr; S_AXI_wdata = data;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      n = 0;
      while (!(S_AXI_awready && S_AXI_wready) && n < 20) begin @(negedge ACLK); n++; end
      chk("aw_handshake", {31'd0, S_AXI_awready & S_AXI_wready}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      n = 0;
      while (!S_AXI_bvalid && n < 20) begin @(negedge ACLK); n++; end
      chk("bvalid", {31'd0, S_AXI_bvalid}, 32'd1);
      S_AXI_bready = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      int n;
      @(negedge ACLK);
      S_AXI_araddr = addr; S_AXI_arvalid = 1'b1;
      n = 0;
      while (!S_AXI_arready && n < 20) begin @(negedge ACLK); n++; end
      chk("ar_handshake", {31'd0, S_AXI_arready}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_arvalid = 1'b0;
      n = 0;
      while (!S_AXI_rvalid && n < 20) begin @(negedge ACLK); n++; end
      chk("rvalid", {31'd0, S_AXI_rvalid}, 32'd1);
      data = S_AXI_rdata;
      S_AXI_rready = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_rready = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      chk(tag, d, exp);
      $display("read  %s addr=0x%0h data=0x%0h", tag, addr, d);
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_end();
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(HALF);
   endtask

   // Shifts nbits MSB-first; MISO is captured just before each SCLK rise.
   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'd0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         wait_clk(HALF);
         mi = {mi[6:0], spi_miso};
         spi_sclk = 1'b1;
         wait_clk(HALF);
         spi_sclk = 1'b0;
      end
      $display("spi   mosi=0x%0h bits=%0d miso=0x%0h", mo, nbits, mi);
   endtask

   initial begin
      logic [7:0] mi;
      ARESETN = 1'b0;
      S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
      S_AXI_wdata = '0; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b0;
      S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
      spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;

      // Reset state
      wait_clk(4);
      chk("reset_outputs", {18'd0, S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bresp,
                            S_AXI_arready, S_AXI_rvalid, S_AXI_rresp, S_AXI_rlast,
                            spi_miso, spi_miso_oe, irq}, 32'd0);
      chk("reset_rdata", S_AXI_rdata, 32'd0);
      ARESETN = 1'b1;
      wait_clk(4);
      read_chk("ctrl_reset", A_CTRL, 32'h1);
      read_chk("status_reset", A_STAT, 32'h0);

      // TX 0xA5 while master sends 0x3C
      axi_write(A_TX, 32'hA5);
      read_chk("status_txv", A_STAT, 32'h2);
      read_chk("txdata", A_TX, 32'hA5);
      cs_begin();
      chk("oe_active", {31'd0, spi_miso_oe}, 32'd1);
      read_chk("status_busy", A_STAT, 32'h4);
      spi_bits(8'h3C, 8, mi);
      chk("miso_a5", {24'd0, mi}, 32'hA5);
      cs_end();
      chk("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
      read_chk("status_rxv", A_STAT, 32'h1);
      read_chk("rx_3c", A_RX, 32'h3C);
      read_chk("status_clr", A_STAT, 32'h0);

      // No TX pending: fill byte
      cs_begin();
      spi_bits(8'h55, 8, mi);
      chk("miso_fill", {24'd0, mi}, 32'hFF);
      cs_end();
      read_chk("status_fill", A_STAT, 32'h1);
      read_chk("rx_55", A_RX, 32'h55);

      // Two bytes in one frame, RXDATA unread -> overrun; second byte reloads fill
      axi_write(A_TX, 32'h5A);
      cs_begin();
      spi_bits(8'h11, 8, mi);
      chk("miso_5a", {24'd0, mi}, 32'h5A);
      spi_bits(8'h22, 8, mi);
      chk("miso_reload_fill", {24'd0, mi}, 32'hFF);
      cs_end();
      read_chk("status_ovr", A_STAT, 32'h9);
      axi_write(A_STAT, 32'h8);
      read_chk("status_w1c", A_STAT, 32'h1);
      read_chk("rx_11", A_RX, 32'h11);
      read_chk("status_ovr_done", A_STAT, 32'h0);

      // Partial byte discarded
      cs_begin();
      spi_bits(8'hFF, 5, mi);
      cs_end();
      read_chk("status_partial", A_STAT, 32'h0);
      cs_begin();
      spi_bits(8'h7E, 8, mi);
      cs_end();
      read_chk("rx_7e", A_RX, 32'h7E);

      // Interrupt
      axi_write(A_CTRL, 32'h3);
      read_chk("ctrl_irq", A_CTRL, 32'h3);
      chk("irq_low", {31'd0, irq}, 32'd0);
      cs_begin();
      spi_bits(8'h42, 8, mi);
      cs_end();
      chk("irq_high", {31'd0, irq}, 32'd1);
      read_chk("rx_42", A_RX, 32'h42);
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      // Disabled: traffic ignored
      axi_write(A_CTRL, 32'h0);
      cs_begin();
      chk("oe_disabled", {31'd0, spi_miso_oe}, 32'd0);
      spi_bits(8'h12, 8, mi);
      cs_end();
      read_chk("status_disabled", A_STAT, 32'h0);
      axi_write(A_CTRL, 32'h1);

      // Reset mid-byte
      axi_write(A_TX, 32'hC3);
      cs_begin();
      spi_bits(8'hA0, 4, mi);
      chk("miso_partial_c", {24'd0, mi}, 32'h0C);
      ARESETN = 1'b0;
      wait_clk(2);
      chk("midreset_outputs", {18'd0, S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bresp,
                               S_AXI_arready, S_AXI_rvalid, S_AXI_rresp, S_AXI_rlast,
                               spi_miso, spi_miso_oe, irq}, 32'd0);
      ARESETN = 1'b1;
      wait_clk(10);
      chk("oe_after_reset", {31'd0, spi_miso_oe}, 32'd0);
      read_chk("ctrl_after_reset", A_CTRL, 32'h1);
      read_chk("status_after_reset", A_STAT, 32'h0);
      read_chk("tx_after_reset", A_TX, 32'h0);
      cs_end();
      cs_begin();
      chk("oe_new_frame", {31'd0, spi_miso_oe}, 32'd1);
      spi_bits(8'h99, 8, mi);
      chk("miso_after_reset", {24'd0, mi}, 32'hFF);
      cs_end();
      read_chk("rx_99", A_RX, 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
